// File: rtl/metadata_streamer.sv
// metadata_streamer: emits one BEATS-beat metadata record per request as an AXI-Stream set.
// Latency: 2 cycles from generate_md to TVALID when idle; back-to-back sets with no bubble.
// Backpressure: TREADY stalls hold TDATA/TLAST; requests queue up to 2^PEND_W-1, extras drop and set overflow.
//
// Ports:
//   clk, reset        sole clock; asynchronous active-high reset
//   generate_md       one metadata set requested per cycle high
//   ts_mode           0: timestamp = sets_sent+1, 1: timestamp = ext_ts captured with the request
//   ext_ts            external 64-bit timestamp, captured with every accepted request
//   MD_FIXED          fixed metadata field, big-endian bytes, sampled when a set starts
//   clear_ovf         clears the sticky overflow flag (a new drop in the same cycle wins)
//   AXIS_MD_*         AXI-Stream master: TDATA/TVALID/TLAST out, TREADY in
//   sets_sent         completed sets (64-bit, wrapping)
//   pending           requested sets not yet started
//   overflow          sticky: at least one request was dropped
module metadata_streamer #(
   parameter int DATA_W  = 512,
   parameter int BEATS   = 2,
   parameter int FIXED_W = 448,
   parameter int PEND_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               generate_md,
   input  logic               ts_mode,
   input  logic [63:0]        ext_ts,
   input  logic [FIXED_W-1:0] MD_FIXED,
   input  logic               clear_ovf,
   output logic [DATA_W-1:0]  AXIS_MD_TDATA,
   output logic               AXIS_MD_TVALID,
   output logic               AXIS_MD_TLAST,
   input  logic               AXIS_MD_TREADY,
   output logic [63:0]        sets_sent,
   output logic [PEND_W-1:0]  pending,
   output logic               overflow
);

   localparam int REC_W  = BEATS * DATA_W;
   localparam int REC_NB = REC_W / 8;
   localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int QDEPTH = 1 << PEND_W;
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Set in flight: its timestamp and fixed field are frozen at set start.
   logic [BCNT_W-1:0]   r_beat;
   logic [63:0]         r_ts;
   logic [FIXED_W-1:0]  r_fixed;

   // Timestamp queue, one entry per accepted request, consumed at set start.
   logic [63:0]         r_tsq [QDEPTH];
   logic [PEND_W-1:0]   r_wr_ptr;
   logic [PEND_W-1:0]   r_rd_ptr;

   logic [DATA_W-1:0]   r_tdata;
   logic                r_tvalid;
   logic                r_tlast;
   logic [63:0]         r_sets_sent;
   logic [PEND_W-1:0]   r_pending;
   logic                r_overflow;

   logic                w_hs;
   logic                w_last_hs;
   logic                w_start;
   logic                w_advance;
   logic                w_finish;
   logic                w_accept;
   logic                w_drop;
   logic [63:0]         w_start_ts;
   logic [63:0]         w_src_ts;
   logic [FIXED_W-1:0]  w_src_fixed;
   logic [BCNT_W-1:0]   w_sel_beat;
   logic [REC_W-1:0]    w_rec;
   logic [REC_W-1:0]    w_rec_sw;
   logic [DATA_W-1:0]   w_beat_dat;

   assign w_hs      = r_tvalid & AXIS_MD_TREADY;
   assign w_last_hs = w_hs & (r_beat == LAST_BEAT);

   // Next-state and per-cycle control.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pending != '0) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_last_hs) begin
               // Chain straight into the next set when one is waiting.
               if (r_pending != '0) begin
                  w_start = 1'b1;
               end else begin
                  w_finish    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_hs) begin
               w_advance = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A full counter still takes a request if a set starts in the same cycle.
   assign w_accept = generate_md & ((r_pending != PEND_MAX) | w_start);
   assign w_drop   = generate_md & ~w_accept;

   // Counter timestamp counts the set completing this cycle, so chained sets get consecutive values.
   assign w_start_ts = ts_mode ? r_tsq[r_rd_ptr]
                               : (r_sets_sent + {63'd0, w_last_hs} + 64'd1);

   // Beat source: the new set's fields on a start, otherwise the frozen fields of the set in flight.
   assign w_src_ts    = w_start ? w_start_ts : r_ts;
   assign w_src_fixed = w_start ? MD_FIXED   : r_fixed;
   assign w_sel_beat  = w_start ? '0 : (r_beat + BCNT_W'(1));

   // Big-endian record {ts, fixed, pad}, then full-width byte reversal so byte 0 of beat 0
   // carries the first big-endian byte.
   always_comb begin
      w_rec    = '0;
      w_rec_sw = '0;
      w_rec[REC_W-1 -: 64]       = w_src_ts;
      w_rec[REC_W-65 -: FIXED_W] = w_src_fixed;
      for (int i = 0; i < REC_NB; i++) begin
         w_rec_sw[i*8 +: 8] = w_rec[(REC_NB-1-i)*8 +: 8];
      end
   end

   always_comb begin
      w_beat_dat = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (w_sel_beat == BCNT_W'(k)) begin
            w_beat_dat = w_rec_sw[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat      <= '0;
         r_ts        <= '0;
         r_fixed     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_sets_sent <= '0;
         r_pending   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_start) begin
            r_ts     <= w_start_ts;
            r_fixed  <= MD_FIXED;
            r_beat   <= '0;
            r_tdata  <= w_beat_dat;
            r_tvalid <= 1'b1;
            r_tlast  <= (BEATS == 1);
            r_rd_ptr <= r_rd_ptr + PEND_W'(1);
         end else if (w_advance) begin
            r_beat  <= r_beat + BCNT_W'(1);
            r_tdata <= w_beat_dat;
            r_tlast <= ((r_beat + BCNT_W'(1)) == LAST_BEAT);
         end else if (w_finish) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end

         if (w_last_hs) begin
            r_sets_sent <= r_sets_sent + 64'd1;
         end

         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PEND_W'(1);
         end

         case ({w_accept, w_start})
            2'b10:   r_pending <= r_pending + PEND_W'(1);
            2'b01:   r_pending <= r_pending - PEND_W'(1);
            default: r_pending <= r_pending;
         endcase

         // A drop in the same cycle as clear_ovf keeps the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Timestamp storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tsq[r_wr_ptr] <= ext_ts;
      end
   end

   assign AXIS_MD_TDATA  = r_tdata;
   assign AXIS_MD_TVALID = r_tvalid;
   assign AXIS_MD_TLAST  = r_tlast;
   assign sets_sent      = r_sets_sent;
   assign pending        = r_pending;
   assign overflow       = r_overflow;

endmodule
